serial_add_sched: RTL and testbench

SERIAL_ADD_SCHED -- requirements
Module: serial_add_sched

---
 rtl/serial_add_sched.sv | 110 +++++++++++
 tb/tb_serial_add_sched.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/serial_add_sched.sv
// rtl/serial_add_sched.sv - bit-serial add/subtract using one shared full adder
// One full adder walks the operands LSB first; the result is latched when DONE is entered.
module serial_add_sched #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             sub_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o,
  output logic             ovf_o
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic ha0_s, ha0_c, ha1_s, ha1_c;
  logic fa_s, fa_c;
  logic last_bit;
  logic accept;

  // Full adder as two half adders plus an OR.
  assign ha0_s = a_sr[0] ^ b_sr[0];
  assign ha0_c = a_sr[0] & b_sr[0];
  assign ha1_s = ha0_s ^ carry;
  assign ha1_c = ha0_s & carry;
  assign fa_s  = ha1_s;
  assign fa_c  = ha0_c | ha1_c;

  assign last_bit = (cnt == CW'(WIDTH - 1));
  assign accept   = (state == IDLE) && start_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    busy_o    = 1'b0;
    done_o    = 1'b0;
    case (state)
      IDLE: begin
        if (start_i) state_nxt = RUN;
      end
      RUN: begin
        busy_o = 1'b1;
        if (last_bit) state_nxt = DONE;
      end
      DONE: begin
        done_o    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      sum_o  <= '0;
      cout_o <= 1'b0;
      ovf_o  <= 1'b0;
    end else if (accept) begin
      // Subtraction is A + ~B + 1: invert B here and seed the carry with 1.
      a_sr  <= a_i;
      b_sr  <= sub_i ? ~b_i : b_i;
      carry <= sub_i;
      cnt   <= '0;
    end else if (state == RUN) begin
      a_sr   <= a_sr >> 1;
      b_sr   <= b_sr >> 1;
      res_sr <= {fa_s, res_sr[WIDTH-1:1]};
      carry  <= fa_c;
      cnt    <= cnt + CW'(1);
      if (last_bit) begin
        // carry still holds the carry into the MSB at this point.
        sum_o  <= {fa_s, res_sr[WIDTH-1:1]};
        cout_o <= fa_c;
        ovf_o  <= carry ^ fa_c;
      end
    end
  end

endmodule

// File: tb/tb_serial_add_sched.sv
// tb/tb_serial_add_sched.sv - self-checking bench for serial_add_sched
// Table vectors, hand-written corner sequences and random operations against an arithmetic model.
module tb_serial_add_sched;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         sub;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  int checks;
  int failures;
  int prev_sum;

  serial_add_sched #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (start),
    .sub_i   (sub),
    .a_i     (a_in),
    .b_i     (b_in),
    .busy_o  (busy),
    .done_o  (done),
    .sum_o   (sum),
    .cout_o  (cout),
    .ovf_o   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       s;
    logic [7:0] es;
    logic       ec;
    logic       eo;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    chk("busy_done_exclusive", int'(busy & done), 0);
  endtask

  // Reference: plain integer arithmetic on the operands.
  function automatic void model(input int a, input int b, input bit s,
                                output int es, output int ec, output int eo);
    int sa, sb, r;
    sa = (a >= 128) ? a - 256 : a;
    sb = (b >= 128) ? b - 256 : b;
    if (s) begin
      es = (a - b) & 255;
      ec = (a >= b) ? 1 : 0;
      r  = sa - sb;
    end else begin
      es = (a + b) & 255;
      ec = ((a + b) > 255) ? 1 : 0;
      r  = sa + sb;
    end
    eo = (r > 127 || r < -128) ? 1 : 0;
  endfunction

  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic s,
                        input int disturb,
                        output logic [7:0] rs, output logic rc, output logic ro);
    int lat;
    bit gap;
    start = 1'b1;
    a_in  = a;
    b_in  = b;
    sub   = s;
    tick();
    lat   = 1;
    gap   = 0;
    start = 1'b0;
    while (!done && lat < 40) begin
      if (!busy) gap = 1;
      if (lat == 4) chk("sum_held_during_run", int'(sum), prev_sum);
      a_in  = 8'($urandom);
      b_in  = 8'($urandom);
      sub   = 1'($urandom);
      start = (lat == disturb);
      tick();
      lat++;
    end
    start = 1'b0;
    chk("latency", lat, W + 1);
    chk("busy_continuous", int'(gap), 0);
    rs = sum;
    rc = cout;
    ro = ovf;
    tick();
    chk("done_one_cycle", int'(done), 0);
    chk("idle_not_busy", int'(busy), 0);
  endtask

  initial begin
    logic [7:0] rs;
    logic       rc, ro;
    int         es, ec, eo;
    bit         seen;
    logic [7:0] ra, rb;
    logic       rsub;

    checks   = 0;
    failures = 0;
    prev_sum = 0;

    tbl[0] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1};
    tbl[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    tbl[2] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    tbl[3] = '{8'h10, 8'h01, 1'b1, 8'h0F, 1'b1, 1'b0};
    tbl[4] = '{8'h00, 8'h01, 1'b1, 8'hFF, 1'b0, 1'b0};
    tbl[5] = '{8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1};

    rst_n = 1'b0;
    start = 1'b0;
    sub   = 1'b0;
    a_in  = '0;
    b_in  = '0;
    tick();
    tick();
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_sum", int'(sum), 0);
    chk("reset_cout", int'(cout), 0);
    chk("reset_ovf", int'(ovf), 0);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      run_op(tbl[i].a, tbl[i].b, tbl[i].s, -1, rs, rc, ro);
      chk($sformatf("tbl%0d_sum", i), int'(rs), int'(tbl[i].es));
      chk($sformatf("tbl%0d_cout", i), int'(rc), int'(tbl[i].ec));
      chk($sformatf("tbl%0d_ovf", i), int'(ro), int'(tbl[i].eo));
      prev_sum = int'(tbl[i].es);
    end

    // A second start in the third RUN cycle must be ignored.
    run_op(8'h11, 8'h22, 1'b0, 3, rs, rc, ro);
    chk("ignored_start_sum", int'(rs), 8'h33);
    chk("ignored_start_cout", int'(rc), 0);
    prev_sum = 8'h33;

    // Reset during the fourth RUN cycle.
    start = 1'b1;
    a_in  = 8'h5A;
    b_in  = 8'h3C;
    sub   = 1'b0;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    chk("pre_reset_busy", int'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk("midrun_reset_busy", int'(busy), 0);
    chk("midrun_reset_done", int'(done), 0);
    chk("midrun_reset_sum", int'(sum), 0);
    chk("midrun_reset_cout", int'(cout), 0);
    chk("midrun_reset_ovf", int'(ovf), 0);
    rst_n = 1'b1;
    prev_sum = 0;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done) seen = 1;
    end
    chk("no_done_after_abort", int'(seen), 0);
    run_op(8'h01, 8'h02, 1'b0, -1, rs, rc, ro);
    chk("post_reset_sum", int'(rs), 8'h03);
    prev_sum = 3;

    // start held high: done every W+2 cycles, busy only in RUN.
    start = 1'b1;
    a_in  = 8'h5A;
    b_in  = 8'h3C;
    sub   = 1'b0;
    for (int t = 1; t <= 30; t++) begin
      int p;
      tick();
      p = (t - 1) % (W + 2);
      chk($sformatf("held_busy_t%0d", t), int'(busy), (p < W) ? 1 : 0);
      chk($sformatf("held_done_t%0d", t), int'(done), (p == W) ? 1 : 0);
      if (p == W) chk($sformatf("held_sum_t%0d", t), int'(sum), 8'h96);
    end
    start = 1'b0;
    tick();
    prev_sum = 8'h96;

    // Random operations against the arithmetic model.
    for (int i = 0; i < 40; i++) begin
      ra   = 8'($urandom);
      rb   = 8'($urandom);
      rsub = 1'($urandom);
      if (i == 0) begin ra = 8'h00; rb = 8'h00; rsub = 1'b1; end
      if (i == 1) begin ra = 8'h80; rb = 8'h80; rsub = 1'b0; end
      model(int'(ra), int'(rb), rsub, es, ec, eo);
      run_op(ra, rb, rsub, ((i % 4) == 0) ? 1 + (i % 8) : -1, rs, rc, ro);
      chk($sformatf("rnd%0d_sum", i), int'(rs), es);
      chk($sformatf("rnd%0d_cout", i), int'(rc), ec);
      chk($sformatf("rnd%0d_ovf", i), int'(ro), eo);
      prev_sum = es;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
